// File: rtl/rvx_reg_initiator_pkg.sv
// Shared types and constants for the RVX peripheral register-bus initiator.
// Imported by rvx_reg_initiator and usable by any block that talks to it.
package rvx_reg_initiator_pkg;

  localparam int unsigned RVX_REG_INIT_ADDR_WIDTH = 5;
  localparam int unsigned RVX_REG_INIT_TIMEOUT    = 16;
  localparam int unsigned RVX_DATA_WIDTH          = 32;
  localparam int unsigned RVX_STRB_WIDTH          = 4;

  typedef enum logic [1:0] {
    RVX_REG_INIT_IDLE = 2'd0,
    RVX_REG_INIT_WAIT = 2'd1,
    RVX_REG_INIT_RESP = 2'd2
  } rvx_reg_init_state_e;

  // A completion only counts when it matches the direction of the pending command.
  function automatic logic rvx_rsp_matches(input logic is_write,
                                           input logic rd_rsp,
                                           input logic wr_rsp);
    return is_write ? wr_rsp : rd_rsp;
  endfunction

endpackage

// File: rtl/rvx_reg_initiator.sv
// Initiator side of the RVX register bus: one command in flight, single-cycle
// request pulse, bounded wait for the peripheral, registered response port.
module rvx_reg_initiator
  import rvx_reg_initiator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = RVX_REG_INIT_ADDR_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = RVX_REG_INIT_TIMEOUT
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_address,
  input  logic [RVX_DATA_WIDTH-1:0] cmd_wdata,
  input  logic [RVX_STRB_WIDTH-1:0] cmd_strobe,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [RVX_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_error,
  output logic [ADDR_WIDTH-1:0]     rw_address,
  output logic [RVX_DATA_WIDTH-1:0] write_data,
  output logic [RVX_STRB_WIDTH-1:0] write_strobe,
  output logic                      read_request,
  output logic                      write_request,
  input  logic [RVX_DATA_WIDTH-1:0] read_data,
  input  logic                      read_response,
  input  logic                      write_response
);

  localparam int unsigned         CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  rvx_reg_init_state_e r_state, w_state_nxt;

  logic                      r_cmd_ready,   w_cmd_ready_nxt;
  logic                      r_read_req,    w_read_req_nxt;
  logic                      r_write_req,   w_write_req_nxt;
  logic                      r_is_write,    w_is_write_nxt;
  logic [ADDR_WIDTH-1:0]     r_addr,        w_addr_nxt;
  logic [RVX_DATA_WIDTH-1:0] r_wdata,       w_wdata_nxt;
  logic [RVX_STRB_WIDTH-1:0] r_strobe,      w_strobe_nxt;
  logic [CNT_W-1:0]          r_count,       w_count_nxt;
  logic                      r_rsp_valid,   w_rsp_valid_nxt;
  logic [RVX_DATA_WIDTH-1:0] r_rdata,       w_rdata_nxt;
  logic                      r_error,       w_error_nxt;

  logic w_accept;
  logic w_match;
  logic w_timeout;

  assign w_accept  = (r_state == RVX_REG_INIT_IDLE) && cmd_valid && r_cmd_ready;
  assign w_match   = rvx_rsp_matches(r_is_write, read_response, write_response);
  assign w_timeout = (r_count == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RVX_REG_INIT_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = 1'b0;
    w_read_req_nxt  = 1'b0;
    w_write_req_nxt = 1'b0;
    w_is_write_nxt  = r_is_write;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_strobe_nxt    = r_strobe;
    w_count_nxt     = r_count;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rdata_nxt     = r_rdata;
    w_error_nxt     = r_error;

    unique case (r_state)
      RVX_REG_INIT_IDLE: begin
        // cmd_ready comes up one edge after reset release, then stays high while idle.
        w_cmd_ready_nxt = 1'b1;
        if (w_accept) begin
          w_cmd_ready_nxt = 1'b0;
          w_is_write_nxt  = cmd_write;
          w_addr_nxt      = cmd_address;
          w_wdata_nxt     = cmd_wdata;
          w_strobe_nxt    = cmd_write ? cmd_strobe : '0;
          w_read_req_nxt  = !cmd_write;
          w_write_req_nxt = cmd_write;
          w_count_nxt     = '0;
          w_state_nxt     = RVX_REG_INIT_WAIT;
        end
      end

      RVX_REG_INIT_WAIT: begin
        // A matching completion beats a timeout landing in the same cycle.
        if (w_match) begin
          w_rdata_nxt     = r_is_write ? '0 : read_data;
          w_error_nxt     = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = RVX_REG_INIT_RESP;
        end else if (w_timeout) begin
          w_rdata_nxt     = '0;
          w_error_nxt     = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = RVX_REG_INIT_RESP;
        end else begin
          w_count_nxt = r_count + CNT_W'(1);
        end
      end

      RVX_REG_INIT_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = RVX_REG_INIT_IDLE;
        end
      end

      default: begin
        w_state_nxt = RVX_REG_INIT_IDLE;
      end
    endcase
  end

  // Every output is a flop so nothing on the host side sees peripheral timing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_ready <= 1'b0;
      r_read_req  <= 1'b0;
      r_write_req <= 1'b0;
      r_is_write  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_strobe    <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_error     <= 1'b0;
    end else begin
      r_cmd_ready <= w_cmd_ready_nxt;
      r_read_req  <= w_read_req_nxt;
      r_write_req <= w_write_req_nxt;
      r_is_write  <= w_is_write_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_strobe    <= w_strobe_nxt;
      r_count     <= w_count_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rdata     <= w_rdata_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign read_request  = r_read_req;
  assign write_request = r_write_req;
  assign rw_address    = r_addr;
  assign write_data    = r_wdata;
  assign write_strobe  = r_strobe;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rdata;
  assign rsp_error     = r_error;

endmodule

// File: tb/tb_rvx_reg_initiator.sv
// Randomized scoreboard bench for rvx_reg_initiator: a driver plays host and
// peripheral, while two monitors check the bus side and the response side.
module tb_rvx_reg_initiator;

  localparam int AW = 5;
  localparam int TO = 16;

  typedef struct {
    bit          isWrite;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          e;
  } busExp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          when;
  } rspExp_t;

  logic          clock;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_address;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_strobe;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic [AW-1:0] rw_address;
  logic [31:0]   write_data;
  logic [3:0]    write_strobe;
  logic          read_request;
  logic          write_request;
  logic [31:0]   read_data;
  logic          read_response;
  logic          write_response;

  int      nVectors     = 0;
  int      nMiscompares = 0;
  int      cyc          = 0;
  int      lastHs       = -10;
  int      prevE        = -100;
  busExp_t busQ[$];
  rspExp_t rspQ[$];

  rvx_reg_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_wdata(cmd_wdata), .cmd_strobe(cmd_strobe),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rw_address(rw_address), .write_data(write_data),
    .write_strobe(write_strobe), .read_request(read_request),
    .write_request(write_request), .read_data(read_data),
    .read_response(read_response), .write_response(write_response)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the first matching completion inside the TO-cycle window wins,
  // otherwise the host sees a timeout error at the end of the window.
  function automatic rspExp_t refModel(input bit isWrite, input logic [31:0] rdata,
                                       input int k, input int late, input int e);
    rspExp_t r;
    int first = 0;
    if (k > 0) first = k;
    if (late > 0 && (first == 0 || late < first)) first = late;
    if (first >= 1 && first <= TO) begin
      r.err   = 1'b0;
      r.rdata = isWrite ? 32'h0 : rdata;
      r.when  = e + first;
    end else begin
      r.err   = 1'b1;
      r.rdata = 32'h0;
      r.when  = e + TO;
    end
    return r;
  endfunction

  // k/s/late are 1-based cycle offsets from the request cycle (0 = none):
  // k matching completion, s wrong-direction completion, late extra matching pulse.
  task automatic applyStimulus(input bit isWrite, input logic [4:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [31:0] rdata, input int k, input int s,
                               input int late, input int readyAt, input bit poke,
                               input bit checkB2B);
    int      e;
    int      hs;
    int      lastEvent;
    bit      got;
    busExp_t b;
    @(posedge clock); #1;
    cmd_valid      = 1'b1;
    cmd_write      = isWrite;
    cmd_address    = addr;
    cmd_wdata      = wdata;
    cmd_strobe     = strb;
    read_response  = 1'b0;
    write_response = 1'b0;
    rsp_ready      = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (cyc == lastHs + 1) checkOutput("cmdReadyAfterRsp", 32'(cmd_ready), 32'd1);
      if (cmd_ready) got = 1'b1;
      else begin @(posedge clock); #1; end
    end
    if (!got) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e = cyc + 1;
    if (checkB2B) checkOutput("b2bSpacing", 32'(e - prevE), 32'd4);
    prevE = e;
    b.isWrite = isWrite; b.addr = addr; b.wdata = wdata;
    b.strb = isWrite ? strb : 4'h0; b.e = e;
    busQ.push_back(b);
    rspQ.push_back(refModel(isWrite, rdata, k, late, e));
    lastEvent = e;
    if (k > 0 && e + k - 1 > lastEvent) lastEvent = e + k - 1;
    if (s > 0 && e + s - 1 > lastEvent) lastEvent = e + s - 1;
    if (late > 0 && e + late - 1 > lastEvent) lastEvent = e + late - 1;
    hs = -1;
    for (int c = e; c < e + 80; c++) begin
      @(posedge clock); #1;
      cmd_valid   = poke && hs < 0;
      cmd_write   = 1'($urandom);
      cmd_address = 5'($urandom);
      cmd_wdata   = $urandom;
      cmd_strobe  = 4'($urandom);
      read_response  = ((k > 0 && c == e + k - 1) || (late > 0 && c == e + late - 1)) ? !isWrite
                       : (s > 0 && c == e + s - 1 && isWrite);
      write_response = ((k > 0 && c == e + k - 1) || (late > 0 && c == e + late - 1)) ? isWrite
                       : (s > 0 && c == e + s - 1 && !isWrite);
      read_data = read_response ? rdata : $urandom;
      rsp_ready = (c >= e + readyAt);
      @(negedge clock);
      if (hs >= 0 && c == hs + 1) checkOutput("cmdReadyAfterRsp", 32'(cmd_ready), 32'd1);
      if (hs < 0 && poke) checkOutput("cmdReadyBusy", 32'(cmd_ready), 32'd0);
      if (hs < 0 && rsp_valid && rsp_ready) hs = c;
      if (hs >= 0 && c >= hs && c >= lastEvent) break;
    end
    if (hs < 0) checkOutput("rspHandshakeTimeout", 32'd0, 32'd1);
    lastHs = hs;
    cmd_valid = 1'b0;
  endtask

  // Drop reset while read_request is high; the command must vanish without a response.
  task automatic resetMidRequest();
    bit got = 1'b0;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 5'h11;
    cmd_wdata = 32'h0; cmd_strobe = 4'hF;
    read_response = 1'b0; write_response = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (cmd_ready) got = 1'b1;
      else begin @(posedge clock); #1; end
    end
    if (!got) begin
      checkOutput("rstAcceptTimeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    cmd_valid = 1'b0; read_response = 1'b1; read_data = 32'hBAD0_0BAD;
    #1;
    checkOutput("rstReqBefore", 32'(read_request), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rstReadReq", 32'(read_request), 32'd0);
    checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstCmdReady", 32'(cmd_ready), 32'd0);
    @(posedge clock); @(posedge clock); #3;
    reset_n = 1'b1;
    #1;
    checkOutput("rstCmdReadyPre", 32'(cmd_ready), 32'd0);
    @(posedge clock); #1;
    checkOutput("rstCmdReadyPost", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("rstNoStaleRsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clock); #1;
    read_response = 1'b0;
    lastHs = -10;
    prevE = -100;
  endtask

  initial begin : rspMonitor
    bit      prevValid = 1'b0;
    bit      haveCur = 1'b0;
    rspExp_t cur;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prevValid = 1'b0;
        haveCur = 1'b0;
      end else if (rsp_valid) begin
        if (!prevValid) begin
          if (rspQ.size() == 0) begin
            checkOutput("unexpectedRsp", 32'(rsp_valid), 32'd0);
            haveCur = 1'b0;
          end else begin
            cur = rspQ.pop_front();
            haveCur = 1'b1;
            checkOutput("rspRdata", rsp_rdata, cur.rdata);
            checkOutput("rspError", 32'(rsp_error), 32'(cur.err));
            checkOutput("rspCycle", 32'(cyc), 32'(cur.when));
          end
        end else if (haveCur) begin
          checkOutput("rspHoldRdata", rsp_rdata, cur.rdata);
          checkOutput("rspHoldError", 32'(rsp_error), 32'(cur.err));
        end
        prevValid = !rsp_ready;
      end else begin
        prevValid = 1'b0;
      end
    end
  end

  initial begin : busMonitor
    bit      prevReq = 1'b0;
    bit      hold = 1'b0;
    bit      req;
    busExp_t b;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prevReq = 1'b0;
        hold = 1'b0;
      end else begin
        req = read_request || write_request;
        if (req) begin
          if (prevReq) checkOutput("reqPulseWidth", 32'd1, 32'd0);
          else if (busQ.size() == 0) checkOutput("unexpectedReq", 32'd1, 32'd0);
          else begin
            b = busQ.pop_front();
            hold = 1'b1;
            checkOutput("reqRead", 32'(read_request), 32'(!b.isWrite));
            checkOutput("reqWrite", 32'(write_request), 32'(b.isWrite));
            checkOutput("reqAddr", 32'(rw_address), 32'(b.addr));
            checkOutput("reqWdata", write_data, b.wdata);
            checkOutput("reqStrobe", 32'(write_strobe), 32'(b.strb));
            checkOutput("reqCycle", 32'(cyc), 32'(b.e));
          end
        end else if (hold) begin
          if (rsp_valid) hold = 1'b0;
          else begin
            checkOutput("holdAddr", 32'(rw_address), 32'(b.addr));
            checkOutput("holdWdata", write_data, b.wdata);
            checkOutput("holdStrobe", 32'(write_strobe), 32'(b.strb));
          end
        end
        prevReq = req;
      end
    end
  end

  initial begin : watchdog
    #(20000 * 10);
    nMiscompares++;
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int k, s, late, readyAt;
    bit isWrite;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_wdata = '0; cmd_strobe = '0; rsp_ready = 1'b0; read_data = '0;
    read_response = 1'b0; write_response = 1'b0;
    #2;
    checkOutput("resetCmdReady", 32'(cmd_ready), 32'd0);
    checkOutput("resetRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("resetReadReq", 32'(read_request), 32'd0);
    checkOutput("resetWriteReq", 32'(write_request), 32'd0);
    checkOutput("resetAddr", 32'(rw_address), 32'd0);
    checkOutput("resetWdata", write_data, 32'd0);
    checkOutput("resetStrobe", 32'(write_strobe), 32'd0);
    checkOutput("resetRdata", rsp_rdata, 32'd0);
    checkOutput("resetError", 32'(rsp_error), 32'd0);
    #20;
    reset_n = 1'b1;
    #1;
    checkOutput("releaseCmdReadyPre", 32'(cmd_ready), 32'd0);
    @(posedge clock); #1;
    checkOutput("releaseCmdReadyPost", 32'(cmd_ready), 32'd1);

    applyStimulus(1'b0, 5'h04, 32'h1234_5678, 4'hF, 32'hA5A5_0001, 2, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'h08, 32'hDEAD_BEEF, 4'hF, 32'h0BAD_F00D, 2, 0, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'h0C, 32'h0, 4'h0, 32'h1111_2222, 0, 0, TO + 4, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'h10, 32'h0, 4'h3, 32'h3333_4444, 1, 0, 0, 11, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'h14, 32'h0, 4'h0, 32'h5555_6666, 3, 1, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'h18, 32'hCAFE_0001, 4'h5, 32'h0, TO, 2, 0, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'h1C, 32'h0, 4'h0, 32'h7777_8888, TO + 1, 0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'(i), 5'(i * 3), $urandom, 4'($urandom), $urandom, 2, 0, 0, 0, 1'b0, i > 0);

    resetMidRequest();

    for (int i = 0; i < 40; i++) begin
      isWrite = 1'($urandom);
      case ($urandom_range(0, 9))
        0:       k = 0;
        1:       k = $urandom_range(TO - 2, TO);
        2:       k = $urandom_range(TO + 1, TO + 4);
        default: k = $urandom_range(1, 5);
      endcase
      s       = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, TO + 2);
      late    = ($urandom_range(0, 4) == 0) ? $urandom_range(TO + 1, TO + 6) : 0;
      readyAt = $urandom_range(0, ((k > 0 && k <= TO) ? k : TO) + 4);
      applyStimulus(isWrite, 5'($urandom), $urandom, 4'($urandom), $urandom,
                    k, s, late, readyAt, 1'($urandom), 1'b0);
    end

    repeat (5) @(posedge clock);
    checkOutput("busQDrained", 32'(busQ.size()), 32'd0);
    checkOutput("rspQDrained", 32'(rspQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
